// File: rtl/prodacc_pkg.sv
// Shared types and default widths for the product accumulator.
package prodacc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;
endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / frame-result-out handshake bundle for product_accumulator.
interface product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic              clear;
  logic [CNT_W-1:0]  frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic              busy;

  modport master (
    output clear, frame_len, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, overflow, busy
  );

  modport slave (
    input  clear, frame_len, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, overflow, busy
  );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// ACC_W adder with carry-out. Define PRODACC_SATURATE_EN to clamp the sum
// to all-ones on carry instead of wrapping.
module acc_adder #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);
  logic [ACC_W-1:0] raw;

  assign {carry_o, raw} = {1'b0, a_i} + {1'b0, b_i};

`ifdef PRODACC_SATURATE_EN
  // Once clamped, any further non-zero addend carries again, so it stays clamped.
  assign sum_o = carry_o ? '1 : raw;
`else
  assign sum_o = raw;
`endif
endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products: sums frame_len beats, then holds
// the total until the consumer takes it. Saturation option: PRODACC_SATURATE_EN.
module product_accumulator
  import prodacc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  product_accumulator_if.slave bus
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic             in_ready;
  logic             beat;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  // A beat coinciding with clear is dropped, not handshaken.
  assign beat     = bus.in_valid && in_ready && !bus.clear;
  assign prod_ext = ACC_W'(bus.product);
  assign len_eff  = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  acc_adder #(.ACC_W(ACC_W)) u_add (
    .a_i     (acc_q),
    .b_i     (prod_ext),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (beat) begin
          acc_d   = prod_ext;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          len_d   = len_eff;
          state_d = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
        end
        ACCUM: if (beat) begin
          acc_d = sum;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = HOLD;
        end
        HOLD: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == ACCUM) || (state_q == HOLD);
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 24-bit and a 16-bit instance share stimulus.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus   ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) bus16 ();

  assign bus16.clear     = bus.clear;
  assign bus16.frame_len = bus.frame_len;
  assign bus16.in_valid  = bus.in_valid;
  assign bus16.product   = bus.product;
  assign bus16.out_ready = bus.out_ready;

  product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  product_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  len;
    logic [15:0] p [4];
    int          n;
    logic [23:0] acc;
    logic        ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] p);
    bus.in_valid = 1'b1;
    bus.product  = p;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Feed one table entry back-to-back with out_ready=1 and check the result timing.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus.frame_len = v.len;
    bus.out_ready = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      bus.in_valid = 1'b1;
      bus.product  = v.p[i];
      step();
      if (i < v.n - 1) chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_acc"},       32'(bus.acc_out),   32'(v.acc));
    chk({tag, "_ovf"},       32'(bus.overflow),  32'(v.ovf));
    chk({tag, "_in_ready_lo"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_busy_hold"}, 32'(bus.busy),      32'd1);
    step();
    chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_hi"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vecs[0].len = 8'd4; vecs[0].n = 4;
    vecs[0].p[0] = 16'd100; vecs[0].p[1] = 16'd200; vecs[0].p[2] = 16'd300; vecs[0].p[3] = 16'd400;
    vecs[0].acc = 24'd1000; vecs[0].ovf = 1'b0;
    vecs[1].len = 8'd0; vecs[1].n = 1;
    vecs[1].p[0] = 16'hFFFF; vecs[1].p[1] = 16'd0; vecs[1].p[2] = 16'd0; vecs[1].p[3] = 16'd0;
    vecs[1].acc = 24'd65535; vecs[1].ovf = 1'b0;
    vecs[2].len = 8'd2; vecs[2].n = 2;
    vecs[2].p[0] = 16'd5; vecs[2].p[1] = 16'd5; vecs[2].p[2] = 16'd0; vecs[2].p[3] = 16'd0;
    vecs[2].acc = 24'd10; vecs[2].ovf = 1'b0;
    vecs[3].len = 8'd3; vecs[3].n = 3;
    vecs[3].p[0] = 16'hFFFF; vecs[3].p[1] = 16'hFFFF; vecs[3].p[2] = 16'hFFFF; vecs[3].p[3] = 16'd0;
    vecs[3].acc = 24'h02FFFD; vecs[3].ovf = 1'b0;
    vecs[4].len = 8'd1; vecs[4].n = 1;
    vecs[4].p[0] = 16'd0; vecs[4].p[1] = 16'd0; vecs[4].p[2] = 16'd0; vecs[4].p[3] = 16'd0;
    vecs[4].acc = 24'd0; vecs[4].ovf = 1'b0;

    bus.clear = 1'b0; bus.frame_len = 8'd0; bus.in_valid = 1'b0;
    bus.product = 16'd0; bus.out_ready = 1'b0;

    #12;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc",       32'(bus.acc_out),   32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_ovf",       32'(bus.overflow),  32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // 16-bit instance: carry out of the accumulator.
    bus.frame_len = 8'd2; bus.out_ready = 1'b1;
    beat(16'hFFFF);
    beat(16'h0002);
`ifdef PRODACC_SATURATE_EN
    chk("ovf16_acc", 32'(bus16.acc_out), 32'h0000FFFF);
`else
    chk("ovf16_acc", 32'(bus16.acc_out), 32'h00000001);
`endif
    chk("ovf16_flag",  32'(bus16.overflow), 32'd1);
    chk("ovf16_valid", 32'(bus16.out_valid), 32'd1);
    chk("ovf24_acc",   32'(bus.acc_out),    32'h00010001);
    chk("ovf24_flag",  32'(bus.overflow),   32'd0);
    step();
    beat(16'd5);
    beat(16'd5);
    chk("ovf16_next_acc",  32'(bus16.acc_out),  32'd10);
    chk("ovf16_next_flag", 32'(bus16.overflow), 32'd0);
    step();

    // Backpressure: result held, extra beats refused, then a new beat lands.
    bus.frame_len = 8'd3; bus.out_ready = 1'b0;
    beat(16'd1); beat(16'd2); beat(16'd3);
    bus.in_valid = 1'b1; bus.product = 16'd99; bus.frame_len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_acc",      32'(bus.acc_out),   32'd6);
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_acc",   32'(bus.acc_out),   32'd99);
    step();

    // Clear mid-frame drops the partial sum and the coincident beat.
    bus.frame_len = 8'd4;
    beat(16'd7); beat(16'd7);
    chk("clr_partial", 32'(bus.acc_out), 32'd14);
    chk("clr_busy",    32'(bus.busy),    32'd1);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.product = 16'd7;
    step();
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    chk("clr_acc",   32'(bus.acc_out),   32'd0);
    chk("clr_busy0", 32'(bus.busy),      32'd0);
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    step(); step();
    chk("clr_idle_valid", 32'(bus.out_valid), 32'd0);
    bus.frame_len = 8'd1;
    beat(16'd9);
    chk("clr_new_acc", 32'(bus.acc_out), 32'd9);
    // Clear in HOLD wins over out_ready.
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_hold_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_hold_acc",   32'(bus.acc_out),   32'd0);

    // Asynchronous reset mid-ACCUM, then a bubbly frame.
    bus.frame_len = 8'd3;
    beat(16'd10); beat(16'd20);
    chk("ar_busy_pre", 32'(bus.busy), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_busy",     32'(bus.busy),      32'd0);
    chk("ar_acc",      32'(bus.acc_out),   32'd0);
    chk("ar_in_ready", 32'(bus.in_ready),  32'd1);
    chk("ar_valid",    32'(bus.out_valid), 32'd0);
    #1 reset_n = 1'b1;
    step();
    beat(16'd10);
    step();
    chk("bub_gap_acc", 32'(bus.acc_out), 32'd10);
    beat(16'd20);
    step();
    chk("bub_gap_valid", 32'(bus.out_valid), 32'd0);
    beat(16'd30);
    chk("bub_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_acc",   32'(bus.acc_out),   32'd60);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 8x8 unsigned multiplier's 16-bit product. It accumulates a frame of FRAME_LEN-programmable products into a wider sum using a valid/ready handshake. It presents the frame total with a valid/ready output handshake and a per-frame overflow flag. Used for dot-product and MAC-style labs built on the existing multiplier.

Parameters:
PROD_W, 16, width of incoming product (matches multiplier output q)
ACC_W, 24, accumulator/result width; must be >= PROD_W
CNT_W, 8, width of frame length and beat counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort/clear, highest priority after reset
frame_len  input  CNT_W  products per frame; sampled on first beat of frame; 0 treated as 1
in_valid  input  1  product beat valid
in_ready  output  1  block can accept product
product  input  PROD_W  unsigned product from multiplier
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
acc_out  output  ACC_W  frame sum, stable while out_valid
overflow  output  1  frame sum exceeded ACC_W bits; valid with out_valid
busy  output  1  high in ACCUM or HOLD

Behaviour:
- One clock (clk); reset is asynchronous, active-low (reset_n).
- Reset values: state=IDLE, acc_out=0, overflow=0, out_valid=0, in_ready=1, busy=0, internal count=0, latched len=0.
- Beat accepted when in_valid && in_ready on rising clk.
- States:
  - IDLE: in_ready=1. On a beat: acc=product, count=1, len=max(frame_len,1), overflow=0. Go to HOLD if len==1, else ACCUM.
  - ACCUM: in_ready=1. On a beat: {carry,acc}=acc+product (unsigned, zero-extended), overflow|=carry, count++. When the incremented count==len, go HOLD. No beat means hold all values.
  - HOLD: in_ready=0, out_valid=1, acc_out/overflow frozen. On out_ready go IDLE the next cycle. in_ready is 1 again in that IDLE cycle, not the same cycle as the out_ready handshake.
- Latency: out_valid rises the cycle after the last beat is accepted. Minimum frame period is len+1 cycles plus output handshake.
- frame_len changes mid-frame are ignored until the next frame's first beat.
- Default arithmetic wraps modulo 2^ACC_W. overflow is sticky within a frame and cleared on the first beat of the next frame.
- clear=1 (any state): next state IDLE, acc_out=0, count=0, overflow=0, out_valid=0. A beat presented the same cycle is dropped, and in_ready must not be treated as a handshake. clear during HOLD discards the result even if out_ready=1 that cycle.
- Count saturates at frame boundary. No beats are accepted in HOLD, so no over-count is possible.
- reset_n asserted mid-frame forces reset values immediately. The partial sum is lost.
- out_valid never deasserts without out_ready, except on clear or reset.

Optional Feature:
PRODACC_SATURATE_EN
- Defined: on carry, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame. overflow is set as in the default.
- Undefined: wrap-around as above.

Decomposition:
- Shared package prodacc_pkg holds:
  - state enum: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2
  - default width constants: PROD_W_DEF=16, ACC_W_DEF=24, CNT_W_DEF=8
- One natural sub-module, acc_adder: ACC_W adder with carry-out and optional saturation (the macro is applied there). Handshake/FSM and counter stay in the top level.

Test Plan:
- Reset then frame_len=4, products 100,200,300,400 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, acc_out=1000, overflow=0, in_ready low exactly one cycle.
- frame_len=0, single product 0xFFFF -> treated as len 1: acc_out=65535 next cycle, busy high through HOLD.
- ACC_W=16, frame_len=2, products 0xFFFF,0x0002:
  - default build -> acc_out=0x0001, overflow=1
  - with PRODACC_SATURATE_EN -> acc_out=0xFFFF, overflow=1
  - next frame 5,5 -> acc_out=10, overflow=0
- Backpressure: frame_len=3 products 1,2,3, out_ready held low 5 cycles -> out_valid and acc_out=6 held stable, in_valid=1 ignored (in_ready=0), no beat lost when out_ready finally asserts.
- clear asserted after 2 of 4 beats (products 7,7) -> IDLE next cycle, acc_out=0, no out_valid. New frame frame_len=1 product 9 -> acc_out=9.
- reset_n pulsed low asynchronously mid-ACCUM (between clk edges) -> outputs at reset values immediately. Bubbly in_valid (1,0,1,0...) frame_len=3 products 10,20,30 afterward -> acc_out=60.
